// File: rtl/btn_ctrl_pkg.sv
// Shared types for the button-driven mux select controller.
// Pure declarations: no latency, no flow control.
package btn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } sel_state_t;

    // Counter width for a count limit n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return $clog2((n < 2) ? 2 : n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button, with a press pulse on each debounced rise.
// Level changes 2 + DEBOUNCE_CYCLES clocks after a stable input; no backpressure, press is a single-cycle strobe.
module btn_debounce
    import btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_btn_db,
    output logic o_press
);

    localparam int             W     = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [W-1:0]   C_MAX = W'(DEBOUNCE_CYCLES - 1);

    logic         r_meta;
    logic         r_sync;
    logic         r_db;
    logic         r_press;
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta  <= i_btn_raw;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            // Any sample agreeing with the current level restarts qualification.
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_MAX) begin
                r_db    <= r_sync;
                r_press <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_db = r_db;
    assign o_press  = r_press;

endmodule

// File: rtl/btn_sel_ctrl.sv
// Mux select controller: debounced presses request in0/in1, switches wait for busy low, sel_valid held off while settling.
// sel updates two clocks after a press pulse when idle and not busy; busy stalls the switch indefinitely.
module btn_sel_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   SETTLE_CYCLES   = 16,
    parameter logic RESET_SEL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn_raw,
    input  logic       busy,
    output logic       sel,
    output logic       sel_valid,
    output logic       sel_changed,
    output logic [1:0] btn_db
);

    localparam int              SW         = cnt_w(SETTLE_CYCLES);
    localparam logic [SW-1:0]   C_SET_LOAD = SW'(SETTLE_CYCLES - 1);

    logic [1:0]    w_press;
    logic          w_req;
    logic          w_req_tgt;
    logic          w_eff_tgt;
    logic          w_pend;

    sel_state_t    r_state;
    logic          r_sel;
    logic          r_valid;
    logic          r_changed;
    logic [SW-1:0] r_cnt;
    logic          r_tgt;
    logic          r_pend;

    for (genvar g = 0; g < 2; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_btn_raw (btn_raw[g]),
            .o_btn_db  (btn_db[g]),
            .o_press   (w_press[g])
        );
    end

    // Simultaneous presses are ambiguous and dropped.
    assign w_req     = w_press[0] ^ w_press[1];
    assign w_req_tgt = w_press[1];
    assign w_eff_tgt = w_req ? w_req_tgt : r_tgt;
    assign w_pend    = w_req | r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SETTLE;
            r_sel     <= RESET_SEL;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_cnt     <= C_SET_LOAD;
            r_tgt     <= RESET_SEL;
            r_pend    <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && (w_req_tgt != r_sel)) begin
                        r_tgt   <= w_req_tgt;
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    r_tgt <= w_eff_tgt;
                    if (w_eff_tgt == r_sel) begin
                        r_state <= IDLE;
                    end else if (!busy) begin
                        r_sel     <= w_eff_tgt;
                        r_changed <= 1'b1;
                        r_valid   <= 1'b0;
                        r_cnt     <= C_SET_LOAD;
                        r_state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_req) begin
                        r_pend <= 1'b1;
                        r_tgt  <= w_req_tgt;
                    end
                    // A request caught during the settle window is honoured on exit.
                    if (r_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_pend  <= 1'b0;
                        r_state <= (w_pend && (w_eff_tgt != r_sel)) ? PENDING : IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel         = r_sel;
    assign sel_valid   = r_valid;
    assign sel_changed = r_changed;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Bench for btn_sel_ctrl: directed vector table plus randomized run against a behavioural model.
module tb_btn_sel_ctrl;

    localparam int   DEB = 4;
    localparam int   SET = 3;
    localparam logic RS  = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic       busy;
    logic       sel;
    logic       sel_valid;
    logic       sel_changed;
    logic [1:0] btn_db;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    btn_sel_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (SET),
        .RESET_SEL       (RS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .busy        (busy),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .sel_changed (sel_changed),
        .btn_db      (btn_db)
    );

    // Behavioural model: "want" is the outstanding target (-1 = none),
    // "settle" the number of settle clocks still to run.
    int         m_want;
    int         m_settle;
    bit         m_sel, m_valid, m_changed;
    bit  [1:0]  m_db, m_press, m_meta, m_sync;
    logic [1:0] sq[$];

    task automatic model_reset();
        m_want = -1; m_settle = SET; m_sel = RS; m_valid = 0; m_changed = 0;
        m_db = 0; m_press = 0; m_meta = 0; m_sync = 0;
        sq.delete();
    endtask

    task automatic model_step(input logic [1:0] raw, input logic bsy);
        bit       req, tgt, stable;
        bit [1:0] new_db;
        req = m_press[0] ^ m_press[1];
        tgt = m_press[1];
        m_changed = 0;
        if (m_settle > 0) begin
            if (req) m_want = tgt;
            m_settle = m_settle - 1;
            if (m_settle == 0) begin
                m_valid = 1;
                if (m_want == int'(m_sel)) m_want = -1;
            end
        end else if (m_want < 0) begin
            if (req && tgt != m_sel) m_want = tgt;
        end else begin
            if (req) m_want = tgt;
            if (m_want == int'(m_sel)) m_want = -1;
            else if (!bsy) begin
                m_sel = (m_want == 1); m_changed = 1; m_valid = 0;
                m_settle = SET; m_want = -1;
            end
        end
        // A button level flips once its last DEB synchronised samples all disagree with it.
        sq.push_back(m_sync);
        if (sq.size() > DEB) void'(sq.pop_front());
        new_db = m_db;
        for (int b = 0; b < 2; b++) begin
            stable = (sq.size() == DEB);
            for (int i = 0; i < sq.size(); i++)
                if (sq[i][b] == m_db[b]) stable = 0;
            if (stable) new_db[b] = ~m_db[b];
        end
        m_press = new_db & ~m_db;
        m_db    = new_db;
        m_sync  = m_meta;
        m_meta  = raw;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [1:0] r, input logic b);
        btn_raw = r;
        busy    = b;
        @(posedge clk);
        model_step(r, b);
        #1;
        chk("sel", 32'(sel), 32'(m_sel));
        chk("sel_valid", 32'(sel_valid), 32'(m_valid));
        chk("sel_changed", 32'(sel_changed), 32'(m_changed));
        chk("btn_db", 32'(btn_db), 32'(m_db));
        if (sel_changed) pulses++;
    endtask

    task automatic do_reset(input logic [1:0] r);
        btn_raw = r;
        busy    = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst sel", 32'(sel), 32'(RS));
        chk("rst sel_valid", 32'(sel_valid), 0);
        chk("rst sel_changed", 32'(sel_changed), 0);
        chk("rst btn_db", 32'(btn_db), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] raw;
        logic       bsy;
        int         ncyc;
        logic       e_sel;
        logic       e_valid;
        logic [1:0] e_db;
        int         e_pulses;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [1:0] raw, input logic bsy, input int ncyc,
                       input logic e_sel, input logic e_valid, input logic [1:0] e_db, input int e_pulses);
        vec_t v;
        v.rst = rst; v.raw = raw; v.bsy = bsy; v.ncyc = ncyc;
        v.e_sel = e_sel; v.e_valid = e_valid; v.e_db = e_db; v.e_pulses = e_pulses;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr;
        logic       bb;
        rst_n   = 1'b1;
        btn_raw = 2'b00;
        busy    = 1'b0;
        model_reset();
        #3;

        // Reset release and settle window
        add(1, 2'b00, 0, 2, 0, 0, 2'b00, 0);
        add(0, 2'b00, 0, 1, 0, 1, 2'b00, 0);
        add(0, 2'b00, 0, 4, 0, 1, 2'b00, 0);
        // btn[1] press, busy low
        add(0, 2'b10, 0, 5, 0, 1, 2'b00, 0);
        add(0, 2'b10, 0, 1, 0, 1, 2'b10, 0);
        add(0, 2'b10, 0, 1, 0, 1, 2'b10, 0);
        add(0, 2'b10, 0, 1, 1, 0, 2'b10, 1);
        add(0, 2'b10, 0, 2, 1, 0, 2'b10, 0);
        add(0, 2'b10, 0, 1, 1, 1, 2'b10, 0);
        add(0, 2'b00, 0, 8, 1, 1, 2'b00, 0);
        // Bounce
        add(0, 2'b10, 0, 1, 1, 1, 2'b00, 0);
        add(0, 2'b00, 0, 1, 1, 1, 2'b00, 0);
        add(0, 2'b10, 0, 1, 1, 1, 2'b00, 0);
        add(0, 2'b00, 0, 8, 1, 1, 2'b00, 0);
        // Busy stalls the switch
        add(1, 2'b00, 0, 3, 0, 1, 2'b00, 0);
        add(0, 2'b10, 1, 6, 0, 1, 2'b10, 0);
        add(0, 2'b10, 1, 20, 0, 1, 2'b10, 0);
        add(0, 2'b10, 0, 1, 1, 0, 2'b10, 1);
        add(0, 2'b10, 0, 3, 1, 1, 2'b10, 0);
        // Cancel while pending, then simultaneous press
        add(1, 2'b00, 0, 3, 0, 1, 2'b00, 0);
        add(0, 2'b10, 1, 8, 0, 1, 2'b10, 0);
        add(0, 2'b11, 1, 8, 0, 1, 2'b11, 0);
        add(0, 2'b11, 0, 5, 0, 1, 2'b11, 0);
        add(0, 2'b00, 0, 8, 0, 1, 2'b00, 0);
        add(0, 2'b11, 0, 12, 0, 1, 2'b11, 0);
        add(0, 2'b00, 0, 8, 0, 1, 2'b00, 0);
        // Request during settle is replayed
        add(0, 2'b10, 0, 3, 0, 1, 2'b00, 0);
        add(0, 2'b11, 0, 4, 0, 1, 2'b10, 0);
        add(0, 2'b11, 0, 1, 1, 0, 2'b10, 1);
        add(0, 2'b11, 0, 1, 1, 0, 2'b11, 0);
        add(0, 2'b11, 0, 1, 1, 0, 2'b11, 0);
        add(0, 2'b11, 0, 1, 1, 1, 2'b11, 0);
        add(0, 2'b11, 0, 1, 0, 0, 2'b11, 1);
        add(0, 2'b11, 0, 3, 0, 1, 2'b11, 0);
        add(0, 2'b00, 0, 8, 0, 1, 2'b00, 0);
        // Reset mid-settle with a latched request, buttons held through reset
        add(0, 2'b10, 0, 3, 0, 1, 2'b00, 0);
        add(0, 2'b11, 0, 7, 1, 0, 2'b11, 1);
        add(1, 2'b11, 0, 3, 0, 1, 2'b00, 0);
        add(0, 2'b11, 0, 10, 0, 1, 2'b11, 0);
        add(0, 2'b00, 0, 8, 0, 1, 2'b00, 0);

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset(tbl[k].raw);
            pulses = 0;
            for (int c = 0; c < tbl[k].ncyc; c++) tick(tbl[k].raw, tbl[k].bsy);
            chk($sformatf("row%0d sel", k), 32'(sel), 32'(tbl[k].e_sel));
            chk($sformatf("row%0d sel_valid", k), 32'(sel_valid), 32'(tbl[k].e_valid));
            chk($sformatf("row%0d btn_db", k), 32'(btn_db), 32'(tbl[k].e_db));
            chk($sformatf("row%0d pulses", k), 32'(pulses), 32'(tbl[k].e_pulses));
        end

        rr = 2'b00;
        bb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset(rr);
            if ($urandom_range(0, 9) == 0) rr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bb = ~bb;
            tick(rr, bb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
